esfa_sequencer: RTL and testbench
=================================

Name: esfa_sequencer

Overview:
- Front-end controller for the ESFA associative memory array.
- Arbitrates between two requesters using round-robin order, with one operation outstanding at a time.
- Expands each high-level command into a fixed micro-sequence of selector opcodes.
- Drives selector, queried_handle, new_index and new_value to the array, samples resultValue/resultBool, and returns a response to the owning requester.

Parameters:
- SEL_NOP, 0: idle selector; the array performs no update.
- SEL_READ, 1: read the cell addressed by queried_handle.
- SEL_CODE, 2: the array latches given_code.
- SEL_WRITE, 3: write new_index/new_value into the latched available handle.
- SEL_FREE, 4: release the cell addressed by queried_handle.
- SEL_FIND, 5: the array latches available_handle.
- SEL_RANK, 6: the array latches given_rank.
- STEP_CYCLES, 2: cycles each selector value is held; the result is sampled on the last cycle. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- reqN_valid  in  1  request valid (N=0,1)
- reqN_ready  out  1  request accepted this cycle
- reqN_cmd  in  2  0=READ, 1=ALLOC, 2=FREE, 3=CODERANK
- reqN_handle  in  8  handle operand
- reqN_index  in  8  index operand
- reqN_value  in  8  value operand
- rspN_valid  out  1  response valid
- rspN_ready  in  1  response consumed
- rspN_value  out  8  response data
- rspN_bool  out  1  response success/flag
- esfa_selector  out  8  to array selector
- esfa_handle  out  8  to array queried_handle
- esfa_index  out  8  to array new_index
- esfa_value  out  8  to array new_value
- esfa_result_value  in  8  from array resultValue
- esfa_result_bool  in  1  from array resultBool
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE.
  - All ready/valid outputs are 0; rsp data is 0.
  - esfa_selector=SEL_NOP; esfa_handle/index/value are 0.
  - RR pointer set so requester 0 wins the first tie.
  - Reset mid-operation abandons the operation with no response. Any array register update already made is not undone.
- FSM states: IDLE, STEP1, STEP2, RESP.
- IDLE:
  - If any reqN_valid, grant one requester and pulse its reqN_ready for that cycle (combinational on valid in IDLE).
  - Latch cmd, operands and owner; go to STEP1.
  - Only one ready may be high per cycle.
- Arbitration:
  - If both requesters are valid, grant the one not granted last.
  - The pointer updates only on acceptance.
- STEP1 / STEP2:
  - Hold esfa_selector and operands stable for exactly STEP_CYCLES cycles, counted by a 4-bit counter.
  - Sample esfa_result_value/bool at the edge ending the last cycle.
- Micro-sequences:
  - READ: STEP1=SEL_READ, handle=operand handle. Response = sampled value/bool.
  - ALLOC: STEP1=SEL_FIND.
    - If the sampled bool is 0: skip STEP2; respond value=0, bool=0.
    - Else: STEP2=SEL_WRITE with operand index/value; respond value=handle sampled in STEP1, bool=1.
  - FREE: STEP1=SEL_FREE, handle=operand handle. Respond value=operand handle, bool=1.
  - CODERANK: STEP1=SEL_CODE with operand index/value, then STEP2=SEL_RANK. Response = STEP2 sample.
- Selector outside STEP1/STEP2 is always SEL_NOP; operands return to 0.
- Latency: acceptance at edge T.
  - First selector cycle is T+1.
  - One-step command: rspN_valid rises at T+1+STEP_CYCLES.
  - Two-step command: rspN_valid rises at T+1+2*STEP_CYCLES.
- RESP:
  - rspN_valid for the owner only; data is held stable until rspN_ready.
  - Return to IDLE on the cycle after the handshake.
  - No new request is accepted in RESP or on the handshake cycle; the earliest next acceptance is one cycle after that.
  - Requests held valid meanwhile wait with no loss.
- Requester-side rules:
  - Operand changes after acceptance are ignored.
  - reqN_valid deasserted before acceptance is legal (no grant).
  - rspN_ready asserted while rspN_valid is low has no effect.

Test Plan:
- Reset with req0_valid=1 held -> req0_ready=0, esfa_selector=0, busy=0. First release cycle: req0_ready=1.
- req0 READ handle=3; array returns 0x5A/1 -> selector=1 for cycles T+1..T+2, esfa_handle=3; rsp0_valid at T+3 with value=0x5A, bool=1.
- req1 ALLOC index=4 value=0x77; array FIND returns 6/1 -> selector 5 for 2 cycles, then 3 for 2 cycles with index=4, value=0x77; rsp1 value=6, bool=1 at T+5.
- ALLOC with FIND result bool=0 -> SEL_WRITE never driven; response value=0, bool=0 at T+3.
- Both valid continuously, rspN_ready=1 -> grants alternate 0,1,0,1; no requester is granted twice consecutively; single outstanding operation confirmed.
- Hold rsp0_ready=0 for 5 cycles, then reset low mid-STEP2 of CODERANK -> response held stable while waiting. After reset: IDLE, selector=0, no response issued, RR pointer favours requester 0.

Source files
------------

// File: rtl/esfa_sequencer_if.sv
// Requester, response and array-side signals of the ESFA sequencer.
// slave = the sequencer itself, master = requesters plus the array.
interface esfa_sequencer_if;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_cmd, req1_cmd;
    logic [7:0] req0_handle, req1_handle;
    logic [7:0] req0_index, req1_index;
    logic [7:0] req0_value, req1_value;

    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_value, rsp1_value;
    logic       rsp0_bool, rsp1_bool;

    logic [7:0] esfa_selector;
    logic [7:0] esfa_handle;
    logic [7:0] esfa_index;
    logic [7:0] esfa_value;
    logic [7:0] esfa_result_value;
    logic       esfa_result_bool;
    logic       busy;

    modport slave (
        input  req0_valid, req1_valid, req0_cmd, req1_cmd,
               req0_handle, req1_handle, req0_index, req1_index,
               req0_value, req1_value, rsp0_ready, rsp1_ready,
               esfa_result_value, esfa_result_bool,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_value, rsp1_value, rsp0_bool, rsp1_bool,
               esfa_selector, esfa_handle, esfa_index, esfa_value, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_cmd, req1_cmd,
               req0_handle, req1_handle, req0_index, req1_index,
               req0_value, req1_value, rsp0_ready, rsp1_ready,
               esfa_result_value, esfa_result_bool,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_value, rsp1_value, rsp0_bool, rsp1_bool,
               esfa_selector, esfa_handle, esfa_index, esfa_value, busy
    );
endinterface

// File: rtl/esfa_sequencer.sv
// Round-robin front end for the ESFA array: accepts one command at a time,
// plays its selector micro-sequence and returns the result to the owner.
module esfa_sequencer #(
    parameter int STEP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    esfa_sequencer_if.slave  bus
);
    localparam logic [7:0] SEL_NOP   = 8'd0;
    localparam logic [7:0] SEL_READ  = 8'd1;
    localparam logic [7:0] SEL_CODE  = 8'd2;
    localparam logic [7:0] SEL_WRITE = 8'd3;
    localparam logic [7:0] SEL_FREE  = 8'd4;
    localparam logic [7:0] SEL_FIND  = 8'd5;
    localparam logic [7:0] SEL_RANK  = 8'd6;

    localparam logic [1:0] CMD_READ     = 2'd0;
    localparam logic [1:0] CMD_ALLOC    = 2'd1;
    localparam logic [1:0] CMD_FREE     = 2'd2;
    localparam logic [1:0] CMD_CODERANK = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STEP1, STEP2, RESP} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       rr_q, rr_d;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] handle_q, handle_d;
    logic [7:0] index_q, index_d;
    logic [7:0] value_q, value_d;
    logic [7:0] rsp_value_q, rsp_value_d;
    logic       rsp_bool_q, rsp_bool_d;

    logic       grant_any, grant_idx, step_done, rsp_taken;
    logic [1:0] req_valid;
    logic [1:0] win_cmd;
    logic [7:0] win_handle, win_index, win_value;
    logic [7:0] sel_out, handle_out, index_out, value_out;

    // rr_q remembers the last winner; on a tie the other requester goes next.
    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign grant_any  = reset && (state_q == IDLE) && (|req_valid);
    assign grant_idx  = (&req_valid) ? ~rr_q : req_valid[1];
    assign win_cmd    = grant_idx ? bus.req1_cmd    : bus.req0_cmd;
    assign win_handle = grant_idx ? bus.req1_handle : bus.req0_handle;
    assign win_index  = grant_idx ? bus.req1_index  : bus.req0_index;
    assign win_value  = grant_idx ? bus.req1_value  : bus.req0_value;
    assign step_done  = (cnt_q == LAST_CNT);
    assign rsp_taken  = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            rr_q        <= 1'b1;
            cmd_q       <= '0;
            handle_q    <= '0;
            index_q     <= '0;
            value_q     <= '0;
            rsp_value_q <= '0;
            rsp_bool_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            cmd_q       <= cmd_d;
            handle_q    <= handle_d;
            index_q     <= index_d;
            value_q     <= value_d;
            rsp_value_q <= rsp_value_d;
            rsp_bool_q  <= rsp_bool_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cmd_d       = cmd_q;
        handle_d    = handle_q;
        index_d     = index_q;
        value_d     = value_q;
        rsp_value_d = rsp_value_q;
        rsp_bool_d  = rsp_bool_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d  = STEP1;
                    cnt_d    = '0;
                    owner_d  = grant_idx;
                    rr_d     = grant_idx;
                    cmd_d    = win_cmd;
                    handle_d = win_handle;
                    index_d  = win_index;
                    value_d  = win_value;
                end
            end
            STEP1: begin
                if (!step_done) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = '0;
                    case (cmd_q)
                        CMD_READ: begin
                            rsp_value_d = bus.esfa_result_value;
                            rsp_bool_d  = bus.esfa_result_bool;
                            state_d     = RESP;
                        end
                        CMD_ALLOC: begin
                            // A failed FIND skips the write and reports 0/0.
                            rsp_value_d = bus.esfa_result_bool ? bus.esfa_result_value : 8'd0;
                            rsp_bool_d  = bus.esfa_result_bool;
                            state_d     = bus.esfa_result_bool ? STEP2 : RESP;
                        end
                        CMD_FREE: begin
                            rsp_value_d = handle_q;
                            rsp_bool_d  = 1'b1;
                            state_d     = RESP;
                        end
                        default: state_d = STEP2;
                    endcase
                end
            end
            STEP2: begin
                if (!step_done) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d   = '0;
                    state_d = RESP;
                    if (cmd_q == CMD_CODERANK) begin
                        rsp_value_d = bus.esfa_result_value;
                        rsp_bool_d  = bus.esfa_result_bool;
                    end
                end
            end
            default: begin
                if (rsp_taken) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_out    = SEL_NOP;
        handle_out = '0;
        index_out  = '0;
        value_out  = '0;
        case (state_q)
            STEP1: begin
                case (cmd_q)
                    CMD_READ: begin
                        sel_out    = SEL_READ;
                        handle_out = handle_q;
                    end
                    CMD_ALLOC: sel_out = SEL_FIND;
                    CMD_FREE: begin
                        sel_out    = SEL_FREE;
                        handle_out = handle_q;
                    end
                    default: begin
                        sel_out   = SEL_CODE;
                        index_out = index_q;
                        value_out = value_q;
                    end
                endcase
            end
            STEP2: begin
                sel_out   = (cmd_q == CMD_ALLOC) ? SEL_WRITE : SEL_RANK;
                index_out = index_q;
                value_out = value_q;
            end
            default: ;
        endcase
    end

    assign bus.esfa_selector = sel_out;
    assign bus.esfa_handle   = handle_out;
    assign bus.esfa_index    = index_out;
    assign bus.esfa_value    = value_out;
    assign bus.busy          = (state_q != IDLE);
    assign bus.req0_ready    = grant_any && !grant_idx;
    assign bus.req1_ready    = grant_any && grant_idx;
    assign bus.rsp0_valid    = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid    = (state_q == RESP) && owner_q;
    assign bus.rsp0_value    = bus.rsp0_valid ? rsp_value_q : 8'd0;
    assign bus.rsp1_value    = bus.rsp1_valid ? rsp_value_q : 8'd0;
    assign bus.rsp0_bool     = bus.rsp0_valid && rsp_bool_q;
    assign bus.rsp1_bool     = bus.rsp1_valid && rsp_bool_q;
endmodule

// File: tb/tb_esfa_sequencer.sv
// Randomized bench for esfa_sequencer; the array is emulated as a per-
// transaction table of results indexed by the selector value.
module tb_esfa_sequencer;
    localparam int STEP = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    esfa_sequencer_if bus ();

    esfa_sequencer #(.STEP_CYCLES(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic       vld [2];
    logic [1:0] cmd [2];
    logic [7:0] hnd [2];
    logic [7:0] idx [2];
    logic [7:0] val [2];
    logic       rsp_rdy [2];
    logic [7:0] rv_tab [8];
    logic       rb_tab [8];

    assign bus.req0_valid  = vld[0];
    assign bus.req1_valid  = vld[1];
    assign bus.req0_cmd    = cmd[0];
    assign bus.req1_cmd    = cmd[1];
    assign bus.req0_handle = hnd[0];
    assign bus.req1_handle = hnd[1];
    assign bus.req0_index  = idx[0];
    assign bus.req1_index  = idx[1];
    assign bus.req0_value  = val[0];
    assign bus.req1_value  = val[1];
    assign bus.rsp0_ready  = rsp_rdy[0];
    assign bus.rsp1_ready  = rsp_rdy[1];
    assign bus.esfa_result_value = rv_tab[bus.esfa_selector[2:0]];
    assign bus.esfa_result_bool  = rb_tab[bus.esfa_selector[2:0]];

    logic       rdy [2];
    logic       rsp_v [2];
    logic [7:0] rsp_val [2];
    logic       rsp_b [2];
    assign rdy[0] = bus.req0_ready;
    assign rdy[1] = bus.req1_ready;
    assign rsp_v[0] = bus.rsp0_valid;
    assign rsp_v[1] = bus.rsp1_valid;
    assign rsp_val[0] = bus.rsp0_value;
    assign rsp_val[1] = bus.rsp1_value;
    assign rsp_b[0] = bus.rsp0_bool;
    assign rsp_b[1] = bus.rsp1_bool;

    int n_checks = 0;
    int n_errors = 0;
    int last_grant;
    int txn_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic new_stim(input int r);
        cmd[r] = 2'($urandom_range(0, 3));
        hnd[r] = 8'($urandom);
        idx[r] = 8'($urandom);
        val[r] = 8'($urandom);
    endtask

    task automatic rand_tables();
        for (int k = 0; k < 8; k++) begin
            rv_tab[k] = 8'($urandom);
            rb_tab[k] = 1'($urandom);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check_eq({tag, "_sel"}, 32'(bus.esfa_selector), 32'(0));
        check_eq({tag, "_ops"}, {8'h0, bus.esfa_handle, bus.esfa_index, bus.esfa_value}, 32'(0));
        check_eq({tag, "_rspv"}, {30'h0, rsp_v[1], rsp_v[0]}, 32'(0));
    endtask

    // Entered just after a negedge with the DUT idle and requests driven.
    task automatic run_txn(input int rsp_wait);
        int g, o, nsteps;
        logic [1:0] c;
        logic [7:0] h, i, v, exp_val;
        logic exp_bool;
        logic [7:0] s_sel [2];
        bit s_chk_h [2];
        bit s_chk_iv [2];
        #1;
        g = (vld[0] && vld[1]) ? 1 - last_grant : (vld[1] ? 1 : 0);
        o = 1 - g;
        check_eq("ready_winner", 32'(rdy[g]), 32'(1));
        check_eq("ready_loser", 32'(rdy[o]), 32'(0));
        c = cmd[g]; h = hnd[g]; i = idx[g]; v = val[g];
        s_chk_h = '{0, 0}; s_chk_iv = '{0, 0};
        case (c)
            2'd0: begin
                nsteps = 1; s_sel[0] = 8'd1; s_chk_h[0] = 1;
                exp_val = rv_tab[1]; exp_bool = rb_tab[1];
            end
            2'd1: begin
                s_sel[0] = 8'd5; s_sel[1] = 8'd3; s_chk_iv[1] = 1;
                nsteps = rb_tab[5] ? 2 : 1;
                exp_val = rb_tab[5] ? rv_tab[5] : 8'd0; exp_bool = rb_tab[5];
            end
            2'd2: begin
                nsteps = 1; s_sel[0] = 8'd4; s_chk_h[0] = 1;
                exp_val = h; exp_bool = 1'b1;
            end
            default: begin
                nsteps = 2; s_sel[0] = 8'd2; s_sel[1] = 8'd6; s_chk_iv[0] = 1;
                exp_val = rv_tab[6]; exp_bool = rb_tab[6];
            end
        endcase
        last_grant = g;
        @(posedge clk); #1;
        vld[g] = 1'b0;
        new_stim(g);
        for (int s = 0; s < nsteps; s++) begin
            for (int k = 0; k < STEP; k++) begin
                @(negedge clk); #1;
                check_eq("step_sel", 32'(bus.esfa_selector), 32'(s_sel[s]));
                if (s_chk_h[s]) check_eq("step_handle", 32'(bus.esfa_handle), 32'(h));
                if (s_chk_iv[s]) check_eq("step_idxval", {16'h0, bus.esfa_index, bus.esfa_value}, {16'h0, i, v});
                check_eq("step_busy", 32'(bus.busy), 32'(1));
                check_eq("step_rspv", {30'h0, rsp_v[1], rsp_v[0]}, 32'(0));
                check_eq("step_no_grant", 32'(rdy[o]), 32'(0));
            end
        end
        @(negedge clk); #1;
        check_eq("rsp_valid_owner", 32'(rsp_v[g]), 32'(1));
        check_eq("rsp_valid_other", 32'(rsp_v[o]), 32'(0));
        check_eq("rsp_value", 32'(rsp_val[g]), 32'(exp_val));
        check_eq("rsp_bool", 32'(rsp_b[g]), 32'(exp_bool));
        check_eq("rsp_sel_nop", 32'(bus.esfa_selector), 32'(0));
        for (int w = 0; w < rsp_wait; w++) begin
            rsp_rdy[o] = 1'($urandom);
            @(negedge clk); #1;
            check_eq("hold_valid", 32'(rsp_v[g]), 32'(1));
            check_eq("hold_value", {23'h0, rsp_b[g], rsp_val[g]}, {23'h0, exp_bool, exp_val});
            check_eq("hold_no_grant", 32'(rdy[o]), 32'(0));
        end
        rsp_rdy[o] = 1'b0;
        rsp_rdy[g] = 1'b1;
        @(negedge clk);
        rsp_rdy[g] = 1'b0;
        #1;
        check_idle("after_rsp");
        $display("txn %0d: req%0d cmd=%0d h=%02h i=%02h v=%02h -> value=%02h bool=%0d wait=%0d",
                 txn_no, g, c, h, i, v, exp_val, exp_bool, rsp_wait);
        txn_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        vld = '{0, 0};
        rsp_rdy = '{0, 0};
        for (int r = 0; r < 2; r++) new_stim(r);
        for (int k = 0; k < 8; k++) begin rv_tab[k] = 8'h0; rb_tab[k] = 1'b0; end

        // Reset held with a pending request: nothing may be granted.
        vld[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_ready0", 32'(rdy[0]), 32'(0));
        check_idle("reset");
        last_grant = 1;

        cmd[0] = 2'd0; hnd[0] = 8'd3;
        rv_tab[1] = 8'h5A; rb_tab[1] = 1'b1;
        reset = 1'b1;
        run_txn(0);

        vld[1] = 1'b1; cmd[1] = 2'd1; idx[1] = 8'd4; val[1] = 8'h77;
        rv_tab[5] = 8'd6; rb_tab[5] = 1'b1;
        run_txn(1);

        vld[0] = 1'b1; cmd[0] = 2'd1;
        rv_tab[5] = 8'h99; rb_tab[5] = 1'b0;
        run_txn(0);

        vld[1] = 1'b1; cmd[1] = 2'd2; hnd[1] = 8'hC3;
        run_txn(2);

        // Both requesters continuously valid: grants must alternate.
        for (int n = 0; n < 6; n++) begin
            for (int r = 0; r < 2; r++) if (!vld[r]) begin new_stim(r); vld[r] = 1'b1; end
            rand_tables();
            run_txn(0);
        end

        vld[1] = 1'b0;
        vld[0] = 1'b1; new_stim(0); cmd[0] = 2'd3; rand_tables();
        run_txn(5);

        // Second CODERANK from req0, abandoned by reset during its STEP2.
        vld[0] = 1'b1; new_stim(0); cmd[0] = 2'd3; rand_tables();
        #1;
        check_eq("abort_ready0", 32'(rdy[0]), 32'(1));
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (STEP + 1) @(negedge clk);
        #1;
        check_eq("abort_in_step2", 32'(bus.esfa_selector), 32'(6));
        reset = 1'b0;
        vld = '{1, 1};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check_idle("abort_reset");
            check_eq("abort_no_ready", {30'h0, rdy[1], rdy[0]}, 32'(0));
        end
        last_grant = 1;
        reset = 1'b1;
        run_txn(0);

        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++)
                if (!vld[r] && $urandom_range(0, 2) != 0) begin new_stim(r); vld[r] = 1'b1; end
            if (!vld[0] && !vld[1]) begin
                int r = int'($urandom_range(0, 1));
                new_stim(r);
                vld[r] = 1'b1;
            end
            rand_tables();
            run_txn(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
